csr_access_ctrl: RTL and testbench

- Sequences all accesses to the machine-mode CSR register file: executes Zicsr instructions (CSRRW/S/C and immediate forms) as read-modify-write and returns the old value for rd.
- Arbitrates the single CSR write port between the instruction path and the trap-entry path (MEPC/MCAUSE update). The trap path has priority.
- Sits between execute stage and the CSR register file; the CSR file read is combinational and its write is synchronous on csr_we.

---
 rtl/csr_access_ctrl_if.sv | 51 +++++
 rtl/csr_access_ctrl.sv | 149 ++++++++++++++
 tb/tb_csr_access_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_access_ctrl_if.sv
// Bundle of the request, response, trap and CSR-file signals around csr_access_ctrl.
// The slave side is the controller; the master side is the execute stage plus the CSR file.
interface csr_access_ctrl_if #(
    parameter int XLEN   = 64,
    parameter int CSR_AW = 12
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_funct3;
    logic [CSR_AW-1:0] req_addr;
    logic [XLEN-1:0]   req_rs1_val;
    logic [4:0]        req_rs1_idx;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_illegal;

    logic              trap_valid;
    logic              trap_ready;
    logic [XLEN-1:0]   trap_epc;
    logic [XLEN-1:0]   trap_cause;

    logic [CSR_AW-1:0] csr_raddr;
    logic [XLEN-1:0]   csr_rdata;
    logic [CSR_AW-1:0] csr_waddr;
    logic [XLEN-1:0]   csr_wdata;
    logic              csr_we;

    modport slave (
        input  req_valid, req_funct3, req_addr, req_rs1_val, req_rs1_idx,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_illegal,
        input  rsp_ready,
        input  trap_valid, trap_epc, trap_cause,
        output trap_ready,
        output csr_raddr, csr_waddr, csr_wdata, csr_we,
        input  csr_rdata
    );

    modport master (
        output req_valid, req_funct3, req_addr, req_rs1_val, req_rs1_idx,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_illegal,
        output rsp_ready,
        output trap_valid, trap_epc, trap_cause,
        input  trap_ready,
        input  csr_raddr, csr_waddr, csr_wdata, csr_we,
        output csr_rdata
    );
endinterface

// File: rtl/csr_access_ctrl.sv
// Sequences Zicsr read-modify-write accesses and trap-entry MEPC/MCAUSE writes
// onto the single write port of the machine-mode CSR file; traps take priority.
module csr_access_ctrl #(
    parameter int                XLEN        = 64,
    parameter int                CSR_AW      = 12,
    parameter logic [CSR_AW-1:0] MEPC_ADDR   = 12'h341,
    parameter logic [CSR_AW-1:0] MCAUSE_ADDR = 12'h342
) (
    input logic               clk,
    input logic               rst_n,
    csr_access_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE, READ, WRITE, RESP, TRAP_EPC, TRAP_CAUSE
    } state_t;

    state_t            state_q, state_d;
    logic              active_q;
    logic [2:0]        funct3_q, funct3_d;
    logic [CSR_AW-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   rs1_val_q, rs1_val_d;
    logic [4:0]        rs1_idx_q, rs1_idx_d;
    logic [XLEN-1:0]   epc_q, epc_d;
    logic [XLEN-1:0]   cause_q, cause_d;
    logic [XLEN-1:0]   old_q, old_d;
    logic [XLEN-1:0]   wval_q, wval_d;
    logic              illegal_q, illegal_d;

    logic [XLEN-1:0]   operand;
    logic              wr_attempt;
    logic              illegal_now;

    function automatic logic [XLEN-1:0] rmw_value(input logic [1:0]      op,
                                                  input logic [XLEN-1:0] old,
                                                  input logic [XLEN-1:0] opnd);
        case (op)
            2'b01:   rmw_value = opnd;
            2'b10:   rmw_value = old | opnd;
            2'b11:   rmw_value = old & ~opnd;
            default: rmw_value = old;
        endcase
    endfunction

    // Set/clear with x0 (or uimm 0) is a pure read and must not fault on read-only CSRs.
    always_comb begin
        operand     = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_val_q;
        wr_attempt  = (funct3_q[1:0] == 2'b01) || (funct3_q[1] && (rs1_idx_q != 5'd0));
        illegal_now = (funct3_q[1:0] == 2'b00) ||
                      (wr_attempt && (addr_q[CSR_AW-1 -: 2] == 2'b11));
    end

    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        rs1_val_d = rs1_val_q;
        rs1_idx_d = rs1_idx_q;
        epc_d     = epc_q;
        cause_d   = cause_q;
        old_d     = old_q;
        wval_d    = wval_q;
        illegal_d = illegal_q;

        bus.req_ready   = 1'b0;
        bus.trap_ready  = 1'b0;
        bus.rsp_valid   = 1'b0;
        bus.rsp_rdata   = '0;
        bus.rsp_illegal = 1'b0;
        bus.csr_raddr   = '0;
        bus.csr_waddr   = '0;
        bus.csr_wdata   = '0;
        bus.csr_we      = 1'b0;

        case (state_q)
            IDLE: begin
                bus.trap_ready = active_q;
                bus.req_ready  = active_q && !bus.trap_valid;
                if (active_q && bus.trap_valid) begin
                    epc_d   = bus.trap_epc;
                    cause_d = bus.trap_cause;
                    state_d = TRAP_EPC;
                end else if (active_q && bus.req_valid) begin
                    funct3_d  = bus.req_funct3;
                    addr_d    = bus.req_addr;
                    rs1_val_d = bus.req_rs1_val;
                    rs1_idx_d = bus.req_rs1_idx;
                    state_d   = READ;
                end
            end
            READ: begin
                bus.csr_raddr = addr_q;
                old_d         = bus.csr_rdata;
                wval_d        = rmw_value(funct3_q[1:0], bus.csr_rdata, operand);
                illegal_d     = illegal_now;
                state_d       = (!illegal_now && wr_attempt) ? WRITE : RESP;
            end
            WRITE: begin
                bus.csr_we    = 1'b1;
                bus.csr_waddr = addr_q;
                bus.csr_wdata = wval_q;
                state_d       = RESP;
            end
            RESP: begin
                bus.rsp_valid   = 1'b1;
                bus.rsp_rdata   = illegal_q ? '0 : old_q;
                bus.rsp_illegal = illegal_q;
                if (bus.rsp_ready) state_d = IDLE;
            end
            TRAP_EPC: begin
                bus.csr_we    = 1'b1;
                bus.csr_waddr = MEPC_ADDR;
                bus.csr_wdata = epc_q;
                state_d       = TRAP_CAUSE;
            end
            TRAP_CAUSE: begin
                bus.csr_we    = 1'b1;
                bus.csr_waddr = MCAUSE_ADDR;
                bus.csr_wdata = cause_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshakes stay closed until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        funct3_q  <= funct3_d;
        addr_q    <= addr_d;
        rs1_val_q <= rs1_val_d;
        rs1_idx_q <= rs1_idx_d;
        epc_q     <= epc_d;
        cause_q   <= cause_d;
        old_q     <= old_d;
        wval_q    <= wval_d;
        illegal_q <= illegal_d;
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl: expected responses and CSR writes are queued by
// the stimulus and popped by independent monitors; the CSR file is modelled here.
module tb_csr_access_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    csr_access_ctrl_if #(.XLEN(64), .CSR_AW(12)) bus ();

    csr_access_ctrl #(.XLEN(64), .CSR_AW(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] rdata;
        logic        ill;
    } rsp_t;

    typedef struct {
        logic [11:0] addr;
        logic [63:0] data;
    } wr_t;

    rsp_t rsp_q[$];
    wr_t  wr_q[$];

    logic [63:0] mem [0:4095];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.csr_rdata = mem[bus.csr_raddr];

    always @(posedge clk) begin
        if (bus.csr_we) mem[bus.csr_waddr] <= bus.csr_wdata;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (rsp_q.size() == 0) begin
                chk("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                chk("rsp_illegal", 64'(bus.rsp_illegal), 64'(e.ill));
            end
        end
    end

    // CSR write monitor
    always @(negedge clk) begin
        if (bus.csr_we) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_we", 64'(bus.csr_we), 64'd0);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                chk("csr_waddr", 64'(bus.csr_waddr), 64'(w.addr));
                chk("csr_wdata", bus.csr_wdata, w.data);
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"},   64'(bus.req_ready),   64'd0);
        chk({tag, "_trap_ready"},  64'(bus.trap_ready),  64'd0);
        chk({tag, "_rsp_valid"},   64'(bus.rsp_valid),   64'd0);
        chk({tag, "_rsp_rdata"},   bus.rsp_rdata,        64'd0);
        chk({tag, "_rsp_illegal"}, 64'(bus.rsp_illegal), 64'd0);
        chk({tag, "_csr_we"},      64'(bus.csr_we),      64'd0);
        chk({tag, "_csr_raddr"},   64'(bus.csr_raddr),   64'd0);
        chk({tag, "_csr_waddr"},   64'(bus.csr_waddr),   64'd0);
        chk({tag, "_csr_wdata"},   bus.csr_wdata,        64'd0);
    endtask

    task automatic do_req(input logic [2:0] f3, input logic [11:0] a, input logic [63:0] v,
                          input logic [4:0] idx, input logic [63:0] exp_rd, input logic exp_ill,
                          input logic exp_we, input logic [63:0] exp_wd, input int exp_lat,
                          input string name);
        bit got_rdy;
        int k;
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_funct3  = f3;
        bus.req_addr    = a;
        bus.req_rs1_val = v;
        bus.req_rs1_idx = idx;
        got_rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.req_ready) begin
                got_rdy = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({name, "_accept"}, 64'(got_rdy), 64'd1);
        if (!got_rdy) begin
            bus.req_valid = 1'b0;
            return;
        end
        rsp_q.push_back('{rdata: exp_rd, ill: exp_ill});
        if (exp_we) wr_q.push_back('{addr: a, data: exp_wd});
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        k = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                k = i;
                break;
            end
        end
        chk({name, "_latency"}, 64'(k), 64'(exp_lat));
        if (bus.rsp_ready) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 4096; i++) mem[i] <= 64'd0;
        mem[12'h340] <= 64'h5;
        mem[12'hF11] <= 64'h489;
        mem[12'hF14] <= 64'h7;

        rst_n           = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_funct3  = 3'b000;
        bus.req_addr    = 12'h000;
        bus.req_rs1_val = 64'd0;
        bus.req_rs1_idx = 5'd0;
        bus.rsp_ready   = 1'b1;
        bus.trap_valid  = 1'b0;
        bus.trap_epc    = 64'd0;
        bus.trap_cause  = 64'd0;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;

        do_req(3'b001, 12'h340, 64'hDEAD_BEEF, 5'd1,  64'h5,         1'b0, 1'b1, 64'hDEAD_BEEF, 3, "csrrw");
        do_req(3'b010, 12'h340, 64'hFFFF,      5'd0,  64'hDEAD_BEEF, 1'b0, 1'b0, 64'd0,         2, "csrrs_x0");
        do_req(3'b001, 12'h300, 64'hF,         5'd2,  64'h0,         1'b0, 1'b1, 64'hF,         3, "csrrw_300");
        do_req(3'b111, 12'h300, 64'h0,         5'd3,  64'hF,         1'b0, 1'b1, 64'hC,         3, "csrrci");
        do_req(3'b001, 12'hF11, 64'h1,         5'd4,  64'h0,         1'b1, 1'b0, 64'd0,         2, "csrrw_ro");
        do_req(3'b010, 12'hF14, 64'h0,         5'd0,  64'h7,         1'b0, 1'b0, 64'd0,         2, "csrrs_ro_x0");
        do_req(3'b100, 12'h340, 64'h1,         5'd1,  64'h0,         1'b1, 1'b0, 64'd0,         2, "f3_100");
        do_req(3'b110, 12'h340, 64'h0,         5'h10, 64'hDEAD_BEEF, 1'b0, 1'b1, 64'hDEAD_BEFF, 3, "csrrsi");
        do_req(3'b011, 12'h340, 64'hFF,        5'd5,  64'hDEAD_BEFF, 1'b0, 1'b1, 64'hDEAD_BE00, 3, "csrrc");

        // Trap and request presented together: trap wins, request waits
        @(negedge clk);
        bus.trap_valid  = 1'b1;
        bus.trap_epc    = 64'h8000_1000;
        bus.trap_cause  = 64'h2;
        bus.req_valid   = 1'b1;
        bus.req_funct3  = 3'b010;
        bus.req_addr    = 12'h341;
        bus.req_rs1_val = 64'd0;
        bus.req_rs1_idx = 5'd0;
        #1;
        chk("trap_req_ready", 64'(bus.req_ready), 64'd0);
        chk("trap_ready", 64'(bus.trap_ready), 64'd1);
        wr_q.push_back('{addr: 12'h341, data: 64'h8000_1000});
        wr_q.push_back('{addr: 12'h342, data: 64'h2});
        @(posedge clk);
        #1 bus.trap_valid = 1'b0;
        @(negedge clk);
        chk("trap_epc_we", 64'(bus.csr_we), 64'd1);
        chk("trap_epc_addr", 64'(bus.csr_waddr), 64'h341);
        chk("trap_epc_req_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        chk("trap_cause_we", 64'(bus.csr_we), 64'd1);
        chk("trap_cause_addr", 64'(bus.csr_waddr), 64'h342);
        chk("trap_cause_req_ready", 64'(bus.req_ready), 64'd0);
        do_req(3'b010, 12'h341, 64'h0, 5'd0, 64'h8000_1000, 1'b0, 1'b0, 64'd0, 2, "rd_mepc");

        // Response stalled for 5 cycles while a trap is waiting
        #1 bus.rsp_ready = 1'b0;
        do_req(3'b001, 12'h340, 64'h1234, 5'd6, 64'hDEAD_BE00, 1'b0, 1'b1, 64'h1234, 3, "stall");
        bus.trap_valid = 1'b1;
        bus.trap_epc   = 64'h2000;
        bus.trap_cause = 64'hB;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("stall_rsp_rdata", bus.rsp_rdata, 64'hDEAD_BE00);
            chk("stall_req_ready", 64'(bus.req_ready), 64'd0);
            chk("stall_trap_ready", 64'(bus.trap_ready), 64'd0);
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        wr_q.push_back('{addr: 12'h341, data: 64'h2000});
        wr_q.push_back('{addr: 12'h342, data: 64'hB});
        @(posedge clk);
        @(posedge clk);
        #1 bus.trap_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset asserted while the WRITE state is active
        bus.req_valid   = 1'b1;
        bus.req_funct3  = 3'b001;
        bus.req_addr    = 12'h340;
        bus.req_rs1_val = 64'hAAAA;
        bus.req_rs1_idx = 5'd7;
        #1;
        chk("midrst_accept", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("midrst_no_write", mem[12'h340], 64'h1234);
        @(negedge clk);
        rst_n = 1'b1;
        do_req(3'b010, 12'h340, 64'h0, 5'd0, 64'h1234, 1'b0, 1'b0, 64'd0, 2, "post_rst");

        repeat (3) @(negedge clk);
        chk("rsp_queue_empty", 64'(rsp_q.size()), 64'd0);
        chk("wr_queue_empty", 64'(wr_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
